// File: rtl/vu_level_ctrl.sv
// ---------------------------------------------------------------------------
// vu_level_ctrl
//
// Frame-synchronous level controller for the VU meter. It sits between the
// UART receiver and the VGA bar renderer.
//
// Each received sample byte is mapped to a bar level in the range 0..BARS.
// The largest level seen during a video frame is kept. At the start of
// vertical blanking that level is committed to the renderer, so the bar only
// changes between frames and never tears. When the signal falls, the bar
// does not drop at once: it decays by one step every DECAY_FRAMES frames.
//
// Optional feature, selected by the macro PEAK_HOLD_EN:
//   defined   - peak is a held peak marker. It holds for HOLD_FRAMES commits
//               and then falls one step per commit, never below the level.
//   undefined - peak simply follows level combinationally.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   rx_data      in   received sample byte, valid while rx_valid=1
//   rx_valid     in   one-cycle strobe from the UART receiver
//   frame_start  in   one-cycle pulse at the start of vertical blanking
//   level        out  committed bar level, 0..BARS
//   level_valid  out  one-cycle pulse each time level is (re)committed
//   peak         out  peak marker level
// ---------------------------------------------------------------------------
module vu_level_ctrl #(
    parameter int DATA_W       = 8,
    parameter int BARS         = 16,
    parameter int LVL_W        = 5,
    parameter int DECAY_FRAMES = 4,
    parameter int HOLD_FRAMES  = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              frame_start,
    output logic [LVL_W-1:0]  level,
    output logic              level_valid,
    output logic [LVL_W-1:0]  peak
);

    // Wide enough for (2^DATA_W) * BARS with no overflow.
    localparam int PROD_W = DATA_W + LVL_W + 1;
    localparam int DCNT_W = $clog2(DECAY_FRAMES) + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               fs_q, fs_d;
    logic [LVL_W-1:0]   pend_q, pend_d;
    logic               seen_q, seen_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               level_valid_q, level_valid_d;
    logic [DCNT_W-1:0]  decay_cnt_q, decay_cnt_d;

    // Sample-to-level mapping: ((x+1)*BARS) >> DATA_W.
    // This sends 0x00 to 0 and the all-ones code to exactly BARS.
    logic [PROD_W-1:0]  prod;
    logic [LVL_W-1:0]   target;

    always_comb begin
        prod   = (PROD_W'(rx_data) + PROD_W'(1)) * PROD_W'(BARS);
        target = prod[DATA_W +: LVL_W];
    end

    // frame_start is registered once before the FSM. This makes the commit
    // land two edges after the pulse is sampled. A byte that arrives in the
    // same cycle as the pulse still belongs to the frame being closed.
    always_comb begin
        fs_d = frame_start;
    end

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        seen_d        = seen_q;
        level_d       = level_q;
        decay_cnt_d   = decay_cnt_q;
        level_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fs_q) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // A pulse seen while committing is dropped (state_d is
                // forced to IDLE regardless of fs_q).
                state_d       = ST_IDLE;
                level_valid_d = 1'b1;
                if (seen_q && (pend_q >= level_q)) begin
                    level_d     = pend_q;
                    decay_cnt_d = '0;
                end else if (decay_cnt_q == DCNT_W'(DECAY_FRAMES - 1)) begin
                    // The decay counter keeps cycling even when the level
                    // is already at 0; only the level saturates.
                    if (level_q != '0) begin
                        level_d = level_q - LVL_W'(1);
                    end
                    decay_cnt_d = '0;
                end else begin
                    decay_cnt_d = decay_cnt_q + DCNT_W'(1);
                end
                pend_d = '0;
                seen_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A byte in the COMMIT cycle opens the next frame. It overrides the
        // clear instead of being merged into the frame being committed.
        if (rx_valid) begin
            if (state_q == ST_COMMIT) begin
                pend_d = target;
            end else if (target > pend_q) begin
                pend_d = target;
            end
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fs_q          <= 1'b0;
            pend_q        <= '0;
            seen_q        <= 1'b0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
            decay_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            fs_q          <= fs_d;
            pend_q        <= pend_d;
            seen_q        <= seen_d;
            level_q       <= level_d;
            level_valid_q <= level_valid_d;
            decay_cnt_q   <= decay_cnt_d;
        end
    end

    assign level       = level_q;
    assign level_valid = level_valid_q;

`ifdef PEAK_HOLD_EN
    localparam int HCNT_W = $clog2(HOLD_FRAMES) + 1;

    logic [LVL_W-1:0]  peak_q, peak_d;
    logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;

    // The marker is evaluated against the level being committed this cycle
    // (level_d), so marker and bar always move together.
    always_comb begin
        peak_d     = peak_q;
        hold_cnt_d = hold_cnt_q;
        if (state_q == ST_COMMIT) begin
            if (level_d >= peak_q) begin
                peak_d     = level_d;
                hold_cnt_d = '0;
            end else if (hold_cnt_q < HCNT_W'(HOLD_FRAMES - 1)) begin
                hold_cnt_d = hold_cnt_q + HCNT_W'(1);
            end else if ((peak_q - LVL_W'(1)) < level_d) begin
                peak_d = level_d;
            end else begin
                peak_d = peak_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q     <= '0;
            hold_cnt_q <= '0;
        end else begin
            peak_q     <= peak_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign peak = peak_q;
`else
    assign peak = level_q;
`endif

endmodule
